// File: rtl/truth_table_checker.sv
// Sweep checker for a 4-input combinational DUT: collects (vector, output) samples,
// compares them against the EXPECTED truth table and reports coverage, mismatches and timeout.
module truth_table_checker #(
  parameter logic [15:0] EXPECTED = 16'h00FA,
  parameter int unsigned TIMEOUT  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        vld,
  input  logic [3:0]  vec_in,
  input  logic        y_in,
  output logic        rdy,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic        dup,
  output logic [4:0]  err_cnt,
  output logic [15:0] cov_map,
  output logic        first_err_vld,
  output logic [3:0]  first_err_idx
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_idle;
  logic        r_rdy;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic        r_timeout;
  logic        r_dup;
  logic [4:0]  r_err;
  logic [15:0] r_cov;
  logic        r_fev;
  logic [3:0]  r_fei;

  logic        w_accept;
  logic        w_mismatch;
  logic [15:0] w_cov_next;
  logic [4:0]  w_err_next;
  logic [7:0]  w_idle_next;

  assign w_accept    = (r_state == S_COLLECT) && vld;
  assign w_mismatch  = (y_in != EXPECTED[vec_in]);
  assign w_cov_next  = r_cov | (16'd1 << vec_in);
  assign w_err_next  = (w_mismatch && (r_err != 5'd31)) ? r_err + 5'd1 : r_err;
  assign w_idle_next = r_idle + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idle    <= '0;
      r_rdy     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
      r_dup     <= 1'b0;
      r_err     <= '0;
      r_cov     <= '0;
      r_fev     <= 1'b0;
      r_fei     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state   <= S_COLLECT;
            r_rdy     <= 1'b1;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
            r_dup     <= 1'b0;
            r_err     <= '0;
            r_cov     <= '0;
            r_fev     <= 1'b0;
            r_fei     <= '0;
            r_idle    <= '0;
          end
        end
        S_COLLECT: begin
          if (w_accept) begin
            r_cov  <= w_cov_next;
            r_err  <= w_err_next;
            r_idle <= '0;
            if (r_cov[vec_in]) r_dup <= 1'b1;
            if (w_mismatch && !r_fev) begin
              r_fev <= 1'b1;
              r_fei <= vec_in;
            end
            // An accept clears the idle count, so completion always beats timeout.
            if (w_cov_next == '1) begin
              r_state <= S_DONE;
              r_rdy   <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == '0);
            end
          end else begin
            r_idle <= w_idle_next;
            if (w_idle_next == IDLE_LIMIT) begin
              r_state   <= S_DONE;
              r_rdy     <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_pass    <= 1'b0;
              r_timeout <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_rdy   <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign rdy           = r_rdy;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign timeout       = r_timeout;
  assign dup           = r_dup;
  assign err_cnt       = r_err;
  assign cov_map       = r_cov;
  assign first_err_vld = r_fev;
  assign first_err_idx = r_fei;

endmodule

// File: tb/tb_truth_table_checker.sv
// Randomized and directed bench for truth_table_checker against a sweep-level reference model.
module tb_truth_table_checker;

  localparam logic [15:0] EXP_TT = 16'h00FA;
  localparam int unsigned TO     = 32;

  logic        clk = 1'b0;
  logic        rst, start, vld, y_in;
  logic [3:0]  vec_in;
  logic        rdy, busy, done, pass, timeout, dup, first_err_vld;
  logic [4:0]  err_cnt;
  logic [15:0] cov_map;
  logic [3:0]  first_err_idx;

  truth_table_checker #(.EXPECTED(EXP_TT), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .vld(vld), .vec_in(vec_in), .y_in(y_in),
    .rdy(rdy), .busy(busy), .done(done), .pass(pass), .timeout(timeout), .dup(dup),
    .err_cnt(err_cnt), .cov_map(cov_map), .first_err_vld(first_err_vld),
    .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: sweep in progress / finished plus accumulated results.
  bit          m_active, m_fin, m_pass, m_to, m_dup, m_fev;
  bit   [15:0] m_cov;
  int          m_err, m_idle, m_fei;
  logic [15:0] tt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_fin = 0; m_pass = 0; m_to = 0; m_dup = 0; m_fev = 0;
    m_cov = '0; m_err = 0; m_idle = 0; m_fei = 0;
  endtask

  task automatic model_step();
    if (rst) model_reset();
    else if (!m_active) begin
      if (start) begin
        model_reset();
        m_active = 1;
      end
    end else if (vld) begin
      if (m_cov[vec_in]) m_dup = 1;
      m_cov[vec_in] = 1'b1;
      if (y_in != tt[vec_in]) begin
        if (!m_fev) begin m_fev = 1; m_fei = int'(vec_in); end
        m_err = (m_err < 31) ? m_err + 1 : 31;
      end
      m_idle = 0;
      if (m_cov == 16'hFFFF) begin
        m_active = 0; m_fin = 1; m_pass = (m_err == 0);
      end
    end else begin
      m_idle++;
      if (m_idle >= int'(TO) - 1) begin
        m_active = 0; m_fin = 1; m_to = 1; m_pass = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("rdy", 32'(rdy), 32'(m_active));
    check("busy", 32'(busy), 32'(m_active));
    check("done", 32'(done), 32'(m_fin));
    check("pass", 32'(pass), 32'(m_pass));
    check("timeout", 32'(timeout), 32'(m_to));
    check("dup", 32'(dup), 32'(m_dup));
    check("err_cnt", 32'(err_cnt), 32'(m_err));
    check("cov_map", 32'(cov_map), 32'(m_cov));
    check("first_err_vld", 32'(first_err_vld), 32'(m_fev));
    if (m_fev) check("first_err_idx", 32'(first_err_idx), 32'(m_fei));
    else       check("first_err_idx_zero", 32'(first_err_idx), 32'd0);
  endtask

  // Apply inputs for one cycle, advance the model, then compare just after the edge.
  task automatic drive(input bit r, input bit s, input bit v, input logic [3:0] vec, input bit y);
    rst = r; start = s; vld = v; vec_in = vec; y_in = y;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic send(input int i, input bit flip);
    logic [3:0] v4;
    v4 = 4'(i);
    drive(0, 0, 1, v4, tt[v4] ^ flip);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] rv;
    tt = EXP_TT;
    model_reset();
    rst = 1; start = 0; vld = 0; vec_in = '0; y_in = 0;
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    check("reset_cov", 32'(cov_map), 32'h0);
    check("reset_done", 32'(done), 32'h0);

    // Clean sweep
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      send(i, 0);
      if (i == 14) check("clean_not_done_early", 32'(done), 32'h0);
    end
    check("clean_done", 32'(done), 32'h1);
    check("clean_pass", 32'(pass), 32'h1);
    check("clean_err", 32'(err_cnt), 32'h0);
    check("clean_cov", 32'(cov_map), 32'hFFFF);
    drive(0, 0, 0, 0, 0);
    check("done_holds", 32'(done), 32'h1);

    // Faults at vectors 3 and 9
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) send(i, (i == 3) || (i == 9));
    check("fault_err", 32'(err_cnt), 32'd2);
    check("fault_idx", 32'(first_err_idx), 32'd3);
    check("fault_vld", 32'(first_err_vld), 32'h1);
    check("fault_pass", 32'(pass), 32'h0);

    // Timeout after 5 vectors
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) send(i, 0);
    n = 0;
    while (!done && n < 100) begin
      drive(0, 0, 0, 0, 0);
      n++;
    end
    check("timeout_idle_cycles", 32'(n), 32'd31);
    check("timeout_flag", 32'(timeout), 32'h1);
    check("timeout_cov", 32'(cov_map), 32'h001F);
    check("timeout_pass", 32'(pass), 32'h0);

    // Duplicate vector 6
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) send(i, 0);
    send(6, 0);
    for (int i = 7; i < 15; i++) send(i, 0);
    check("dup_not_done", 32'(done), 32'h0);
    send(15, 0);
    check("dup_done", 32'(done), 32'h1);
    check("dup_flag", 32'(dup), 32'h1);
    check("dup_pass", 32'(pass), 32'h1);

    // Reset mid-sweep, start ignored during collect
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) drive(0, 1, 1, 4'(i), tt[i]);
      else send(i, 0);
    end
    drive(1, 1, 1, 4'd9, 1);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_cov", 32'(cov_map), 32'h0);
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) send(i, 0);
    check("midrst_resweep_pass", 32'(pass), 32'h1);

    // vld ignored while idle, then saturation
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 4'(i), 1);
    check("idle_vld_cov", 32'(cov_map), 32'h0);
    check("idle_vld_err", 32'(err_cnt), 32'h0);
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) send(i % 8, 1);
    check("sat_err", 32'(err_cnt), 32'd31);
    check("sat_first", 32'(first_err_idx), 32'd0);
    check("sat_busy", 32'(busy), 32'h1);

    // Randomized traffic
    drive(1, 0, 0, 0, 0);
    for (int c = 0; c < 4000; c++) begin
      rv = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 15; k >= 0; k--) if (!m_cov[k]) rv = 4'(k);
      end
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 7, rv, tt[rv] ^ ($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
